// File: rtl/wordle_row_builder_if.sv
// wordle_row_builder_if: keyboard events, answer and
// display/status bundle between game logic and its user.
interface wordle_row_builder_if #(
  parameter int NCELLS = 5
);
  logic                  key_valid;
  logic [4:0]            key_code;
  logic                  key_enter;
  logic                  key_back;
  logic                  new_game;
  logic [5*NCELLS-1:0]   answer;
  logic [7*NCELLS-1:0]   display;
  logic                  busy;
  logic                  solved;
  logic                  game_over;
  logic [2:0]            guesses_used;

  modport master (
    output key_valid, key_code, key_enter,
    output key_back, new_game, answer,
    input  display, busy, solved,
    input  game_over, guesses_used
  );

  modport slave (
    input  key_valid, key_code, key_enter,
    input  key_back, new_game, answer,
    output display, busy, solved,
    output game_over, guesses_used
  );
endinterface

// File: rtl/wordle_row_builder.sv
// wordle_row_builder: assembles a 5-letter guess and scores it
// against a latched answer with a green-then-yellow engine.
module wordle_row_builder #(
  parameter int NCELLS = 5,
  parameter int MAXG   = 6
) (
  input  logic dclk,
  input  logic clr_n,
  wordle_row_builder_if.slave bus
);
  localparam logic [2:0] NC    = 3'(NCELLS);
  localparam logic [2:0] MG    = 3'(MAXG);
  localparam logic [2:0] LAST  = 3'(NCELLS - 1);
  localparam logic [4:0] BLANK = 5'd26;
  localparam logic [1:0] C_GRY = 2'd0;
  localparam logic [1:0] C_GRN = 2'd1;
  localparam logic [1:0] C_YEL = 2'd2;
  localparam logic [1:0] C_RED = 2'd3;

  typedef enum logic [1:0] {
    ENTRY, GREEN, YEL, RESULT
  } state_e;

  state_e              state_q;
  logic [4:0]          let_q [NCELLS];
  logic [1:0]          col_q [NCELLS];
  logic [5*NCELLS-1:0] ans_q;
  logic [NCELLS-1:0]   used_q;
  logic [2:0]          cnt_q;
  logic [2:0]          idx_q;
  logic [2:0]          gu_q;
  logic                busy_q;
  logic                solved_q;
  logic                over_q;

  logic       letter_d;
  logic       hit_d;
  logic [2:0] hit_j_d;
  logic       all_grn_d;
  logic [2:0] gu_d;

  assign letter_d = bus.key_valid &&
                    (bus.key_code < BLANK);
  assign gu_d     = gu_q + 3'd1;

  // lowest unused answer slot holding the letter under test
  always_comb begin
    hit_d   = 1'b0;
    hit_j_d = '0;
    for (int j = NCELLS - 1; j >= 0; j--) begin
      if (!used_q[j] &&
          ans_q[5*j +: 5] == let_q[idx_q]) begin
        hit_d   = 1'b1;
        hit_j_d = 3'(j);
      end
    end
  end

  // whole row currently green
  always_comb begin
    all_grn_d = 1'b1;
    for (int c = 0; c < NCELLS; c++) begin
      if (col_q[c] != C_GRN) all_grn_d = 1'b0;
    end
  end

  for (genvar c = 0; c < NCELLS; c++) begin : g_cell
    assign bus.display[7*c +: 7] = {col_q[c], let_q[c]};
  end

  assign bus.busy         = busy_q;
  assign bus.solved       = solved_q;
  assign bus.game_over    = over_q;
  assign bus.guesses_used = gu_q;

  // entry, scoring and result state machine
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= ENTRY;
      ans_q    <= '0;
      used_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      gu_q     <= '0;
      busy_q   <= 1'b0;
      solved_q <= 1'b0;
      over_q   <= 1'b0;
      for (int c = 0; c < NCELLS; c++) begin
        let_q[c] <= BLANK;
        col_q[c] <= C_GRY;
      end
    end else if (bus.new_game) begin
      state_q  <= ENTRY;
      used_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      gu_q     <= '0;
      busy_q   <= 1'b0;
      solved_q <= 1'b0;
      over_q   <= 1'b0;
      for (int c = 0; c < NCELLS; c++) begin
        let_q[c] <= BLANK;
        col_q[c] <= C_GRY;
      end
    end else begin
      unique case (state_q)
        ENTRY: begin
          if (bus.key_enter) begin
            if (cnt_q == NC) begin
              ans_q   <= bus.answer;
              used_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= GREEN;
              for (int c = 0; c < NCELLS; c++)
                col_q[c] <= C_GRY;
            end else begin
              for (int c = 0; c < NCELLS; c++)
                if (3'(c) < cnt_q) col_q[c] <= C_RED;
            end
          end else if (bus.key_back) begin
            if (cnt_q != 3'd0) begin
              for (int c = 0; c < NCELLS; c++)
                col_q[c] <= C_GRY;
              let_q[cnt_q - 3'd1] <= BLANK;
              cnt_q <= cnt_q - 3'd1;
            end
          end else if (letter_d) begin
            if (cnt_q < NC) begin
              for (int c = 0; c < NCELLS; c++)
                col_q[c] <= C_GRY;
              let_q[cnt_q] <= bus.key_code;
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        GREEN: begin
          for (int c = 0; c < NCELLS; c++) begin
            if (let_q[c] == ans_q[5*c +: 5]) begin
              col_q[c]  <= C_GRN;
              used_q[c] <= 1'b1;
            end
          end
          idx_q   <= '0;
          state_q <= YEL;
        end
        YEL: begin
          if (col_q[idx_q] != C_GRN && hit_d) begin
            col_q[idx_q]    <= C_YEL;
            used_q[hit_j_d] <= 1'b1;
          end
          if (idx_q == LAST) begin
            state_q  <= RESULT;
            busy_q   <= 1'b0;
            gu_q     <= gu_d;
            solved_q <= all_grn_d;
            over_q   <= all_grn_d || (gu_d == MG);
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        RESULT: begin
          if (!over_q && !bus.key_enter &&
              !bus.key_back && letter_d) begin
            for (int c = 0; c < NCELLS; c++) begin
              let_q[c] <= BLANK;
              col_q[c] <= C_GRY;
            end
            let_q[0] <= bus.key_code;
            cnt_q    <= 3'd1;
            state_q  <= ENTRY;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wordle_row_builder.sv
// tb_wordle_row_builder: directed game scenarios checked against a
// cycle-timeline model of the scoring rules.
module tb_wordle_row_builder;
  localparam int N    = 5;
  localparam int MAXG = 6;

  logic dclk = 1'b0;
  logic clr_n;

  wordle_row_builder_if #(.NCELLS(N)) bus();

  wordle_row_builder #(
    .NCELLS(N),
    .MAXG  (MAXG)
  ) dut (
    .dclk (dclk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  always #5 dclk = ~dclk;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  int m_let [N];
  int m_col [N];
  int m_fin [N];
  int m_cnt, m_gu, m_ph;
  bit m_busy, m_solved, m_over, m_res;

  localparam logic [34:0] RST = {5{7'h1A}};
  localparam logic [24:0] CRANE = {5'd4, 5'd13, 5'd0, 5'd17, 5'd2};
  localparam logic [24:0] ABBEY = {5'd24, 5'd4, 5'd1, 5'd1, 5'd0};
  localparam logic [24:0] BOBBY = {5'd24, 5'd1, 5'd1, 5'd14, 5'd1};

  task automatic check(string nm, logic [34:0] got, logic [34:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [34:0] exp_disp();
    logic [34:0] r;
    r = '0;
    for (int c = 0; c < N; c++)
      r[7*c +: 7] = {2'(m_col[c]), 5'(m_let[c])};
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_let[c] = 26;
      m_col[c] = 0;
      m_fin[c] = 0;
    end
    m_cnt = 0; m_gu = 0; m_ph = 0;
    m_busy = 0; m_solved = 0; m_over = 0; m_res = 0;
  endtask

  // wordle scoring by letter counts: greens first, then
  // yellows left to right while unmatched copies remain
  task automatic score(logic [24:0] a);
    int rem [26];
    int t;
    for (int k = 0; k < 26; k++) rem[k] = 0;
    for (int i = 0; i < N; i++) begin
      t = int'(a[5*i +: 5]);
      if (m_let[i] == t) m_fin[i] = 1;
      else begin
        m_fin[i] = 0;
        rem[t]++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_fin[i] != 1 && rem[m_let[i]] > 0) begin
        m_fin[i] = 2;
        rem[m_let[i]]--;
      end
    end
  endtask

  task automatic model_step();
    bit lv;
    bit allg;
    lv = bus.key_valid && (int'(bus.key_code) < 26);
    if (!clr_n || bus.new_game) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      m_ph++;
      for (int i = 0; i < N; i++) begin
        if (m_fin[i] == 1 && m_ph >= 1) m_col[i] = 1;
        else if (m_fin[i] == 2 && m_ph >= 2 + i) m_col[i] = 2;
        else m_col[i] = 0;
      end
      if (m_ph == 6) begin
        allg = 1;
        for (int i = 0; i < N; i++) if (m_fin[i] != 1) allg = 0;
        m_busy = 0;
        m_gu++;
        m_solved = allg;
        m_over = allg || (m_gu == MAXG);
        m_res = 1;
      end
    end else if (m_res) begin
      if (!m_over && !bus.key_enter && !bus.key_back && lv) begin
        for (int c = 0; c < N; c++) begin
          m_let[c] = 26;
          m_col[c] = 0;
        end
        m_let[0] = int'(bus.key_code);
        m_cnt = 1;
        m_res = 0;
      end
    end else if (bus.key_enter) begin
      if (m_cnt == N) begin
        score(bus.answer);
        for (int c = 0; c < N; c++) m_col[c] = 0;
        m_busy = 1;
        m_ph = 0;
      end else begin
        for (int c = 0; c < m_cnt; c++) m_col[c] = 3;
      end
    end else if (bus.key_back) begin
      if (m_cnt > 0) begin
        for (int c = 0; c < N; c++) m_col[c] = 0;
        m_cnt--;
        m_let[m_cnt] = 26;
      end
    end else if (lv) begin
      if (m_cnt < N) begin
        for (int c = 0; c < N; c++) m_col[c] = 0;
        m_let[m_cnt] = int'(bus.key_code);
        m_cnt++;
      end
    end
  endtask

  // compare DUT against the model every cycle
  always @(negedge dclk) begin
    if (chk_en) begin
      check("display", bus.display, exp_disp());
      check("busy", 35'(bus.busy), 35'(m_busy));
      check("solved", 35'(bus.solved), 35'(m_solved));
      check("game_over", 35'(bus.game_over), 35'(m_over));
      check("guesses_used", 35'(bus.guesses_used), 35'(m_gu));
    end
  end

  task automatic cyc();
    @(posedge dclk);
    model_step();
    @(negedge dclk);
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic letter(int code);
    bus.key_valid = 1'b1;
    bus.key_code  = 5'(code);
    cyc();
    bus.key_valid = 1'b0;
  endtask

  task automatic enter();
    bus.key_enter = 1'b1;
    cyc();
    bus.key_enter = 1'b0;
  endtask

  task automatic back();
    bus.key_back = 1'b1;
    cyc();
    bus.key_back = 1'b0;
  endtask

  task automatic newg();
    bus.new_game = 1'b1;
    cyc();
    bus.new_game = 1'b0;
  endtask

  task automatic type_word(logic [24:0] w);
    for (int i = 0; i < N; i++) letter(int'(w[5*i +: 5]));
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.key_enter = 1'b0;
    bus.key_back  = 1'b0;
    bus.new_game  = 1'b0;
    bus.answer    = '0;
    clr_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    idle(2);
    #1 clr_n = 1'b1;
    check("rst_display", bus.display, RST);
    check("rst_busy", 35'(bus.busy), 35'd0);
    check("rst_gu", 35'(bus.guesses_used), 35'd0);

    // all-green win
    bus.answer = CRANE;
    type_word(CRANE);
    enter();
    check("crane_busy", 35'(bus.busy), 35'd1);
    idle(6);
    check("crane_disp", bus.display,
          {7'h24, 7'h2D, 7'h20, 7'h31, 7'h22});
    check("crane_solved", 35'(bus.solved), 35'd1);
    check("crane_over", 35'(bus.game_over), 35'd1);
    check("crane_gu", 35'(bus.guesses_used), 35'd1);
    letter(5);
    check("crane_locked", bus.display,
          {7'h24, 7'h2D, 7'h20, 7'h31, 7'h22});

    // duplicate letters; answer changes while busy
    newg();
    bus.answer = ABBEY;
    type_word(BOBBY);
    enter();
    bus.answer = CRANE;
    idle(6);
    check("bobby_disp", bus.display,
          {7'h38, 7'h01, 7'h21, 7'h0E, 7'h41});
    check("bobby_solved", 35'(bus.solved), 35'd0);
    check("bobby_gu", 35'(bus.guesses_used), 35'd1);
    letter(0);
    check("next_row", bus.display, {{4{7'h1A}}, 7'h00});

    // short enter marks dark red
    newg();
    letter(0);
    letter(1);
    enter();
    check("short_disp", bus.display,
          {{3{7'h1A}}, 7'h61, 7'h60});
    check("short_busy", 35'(bus.busy), 35'd0);
    check("short_gu", 35'(bus.guesses_used), 35'd0);
    back();
    check("back_disp", bus.display, {{4{7'h1A}}, 7'h00});
    back();
    back();
    check("empty_back", bus.display, RST);

    // invalid code, sixth letter, keys during busy
    letter(27);
    check("code27", bus.display, RST);
    type_word(CRANE);
    letter(3);
    check("sixth", bus.display,
          {7'h04, 7'h0D, 7'h00, 7'h11, 7'h02});
    bus.answer = ABBEY;
    enter();
    letter(7);
    back();
    enter();
    idle(3);
    check("busy_keys", bus.display,
          {7'h44, 7'h0D, 7'h40, 7'h11, 7'h02});
    check("busy_keys_gu", 35'(bus.guesses_used), 35'd1);

    // six wrong guesses
    newg();
    bus.answer = CRANE;
    for (int g = 0; g < MAXG; g++) begin
      type_word(BOBBY);
      enter();
      idle(6);
    end
    check("loss_gu", 35'(bus.guesses_used), 35'd6);
    check("loss_over", 35'(bus.game_over), 35'd1);
    check("loss_solved", 35'(bus.solved), 35'd0);
    letter(0);
    newg();
    check("ng_disp", bus.display, RST);
    check("ng_gu", 35'(bus.guesses_used), 35'd0);
    check("ng_over", 35'(bus.game_over), 35'd0);

    // asynchronous reset mid-scoring
    type_word(CRANE);
    enter();
    idle(2);
    check("mid_busy", 35'(bus.busy), 35'd1);
    #2;
    clr_n = 1'b0;
    model_reset();
    #1;
    check("arst_busy", 35'(bus.busy), 35'd0);
    check("arst_disp", bus.display, RST);
    cyc();
    #1 clr_n = 1'b1;
    idle(2);
    check("post_rst", bus.display, RST);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end
endmodule
